alu: RTL and testbench

Single-cycle RV32I execute unit in the core datapath, between decode and writeback. It takes a one-hot instruction vector from the decoder plus the operands (rs1, rs2, 12-bit immediate, PC). It computes the result and registers it on the clock edge. For loads and stores it drives the data-memory address and strobes combinationally, and formats load data into the registered result.

---
 rtl/alu_pkg.sv | 65 ++++++
 rtl/alu_if.sv | 28 ++
 rtl/alu_load_align.sv | 45 ++++
 rtl/alu.sv | 142 ++++++++++++++
 tb/tb_alu.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I execute unit and the decoder that feeds it:
// one-hot opcode bit positions, datapath widths and the lowest-bit-wins helper.
package alu_pkg;

    localparam int XLEN    = 32;
    localparam int DADDR_W = 15;
    localparam int NUM_OPS = 39;

    localparam int OP_LUI   = 0;
    localparam int OP_AUIPC = 1;
    localparam int OP_JAL   = 2;
    localparam int OP_JALR  = 3;
    localparam int OP_BEQ   = 4;
    localparam int OP_BNE   = 5;
    localparam int OP_BLT   = 6;
    localparam int OP_BGE   = 7;
    localparam int OP_BLTU  = 8;
    localparam int OP_BGEU  = 9;
    localparam int OP_LB    = 10;
    localparam int OP_LH    = 11;
    localparam int OP_LW    = 12;
    localparam int OP_LBU   = 13;
    localparam int OP_LHU   = 14;
    localparam int OP_SB    = 15;
    localparam int OP_SH    = 16;
    localparam int OP_SW    = 17;
    localparam int OP_ADDI  = 18;
    localparam int OP_SLTI  = 19;
    localparam int OP_SLTIU = 20;
    localparam int OP_XORI  = 21;
    localparam int OP_ORI   = 22;
    localparam int OP_ANDI  = 23;
    localparam int OP_SLLI  = 24;
    localparam int OP_SRLI  = 25;
    localparam int OP_SRAI  = 26;
    localparam int OP_ADD   = 27;
    localparam int OP_SUB   = 28;
    localparam int OP_SLL   = 29;
    localparam int OP_SLT   = 30;
    localparam int OP_SLTU  = 31;
    localparam int OP_XOR   = 32;
    localparam int OP_SRL   = 33;
    localparam int OP_SRA   = 34;
    localparam int OP_OR    = 35;
    localparam int OP_AND   = 36;
    localparam int OP_FENCE = 37;
    localparam int OP_SYS   = 38;

    typedef logic [NUM_OPS-1:0] op_vec_t;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_B    = 3'd1,
        LD_H    = 3'd2,
        LD_W    = 3'd3,
        LD_BU   = 3'd4,
        LD_HU   = 3'd5
    } load_kind_e;

    // Isolate the lowest set bit so a malformed multi-hot vector still selects one op.
    function automatic op_vec_t lowest_set(input op_vec_t v);
        return v & (~v + {{(NUM_OPS-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/alu_if.sv
// Data-memory port of the execute unit: byte address, load/store strobes,
// store data out and asynchronous read data back.
interface alu_if;
    import alu_pkg::*;

    logic [DADDR_W-1:0] addr;
    logic               rd_en;
    logic               wr_en;
    logic [XLEN-1:0]    dmem_wr_data;
    logic [XLEN-1:0]    dmem_rd_data;

    modport master (
        output addr,
        output rd_en,
        output wr_en,
        output dmem_wr_data,
        input  dmem_rd_data
    );

    modport slave (
        input  addr,
        input  rd_en,
        input  wr_en,
        input  dmem_wr_data,
        output dmem_rd_data
    );

endinterface

// File: rtl/alu_load_align.sv
// Load formatter: picks the byte or half-word lane out of the memory word and
// sign- or zero-extends it. Misaligned lanes are used exactly as given.
module alu_load_align
    import alu_pkg::*;
(
    input  load_kind_e      kind,
    input  logic [1:0]      lane,
    input  logic [XLEN-1:0] rd_data,
    output logic [XLEN-1:0] load_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection for byte and half-word accesses.
    always_comb begin
        byte_s = 8'd0;
        case (lane)
            2'd0:    byte_s = rd_data[7:0];
            2'd1:    byte_s = rd_data[15:8];
            2'd2:    byte_s = rd_data[23:16];
            2'd3:    byte_s = rd_data[31:24];
            default: byte_s = 8'd0;
        endcase
        if (lane[1]) begin
            half_s = rd_data[31:16];
        end else begin
            half_s = rd_data[15:0];
        end
    end

    // Extension according to the load flavour.
    always_comb begin
        load_data = {XLEN{1'b0}};
        case (kind)
            LD_B:    load_data = {{24{byte_s[7]}}, byte_s};
            LD_BU:   load_data = {24'd0, byte_s};
            LD_H:    load_data = {{16{half_s[15]}}, half_s};
            LD_HU:   load_data = {16'd0, half_s};
            LD_W:    load_data = rd_data;
            default: load_data = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu.sv
// Single-cycle RV32I execute unit: one-hot instruction in, registered result out,
// with combinational data-memory address/strobes for loads and stores.
module alu
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [XLEN-1:0]    rs1,
    input  logic [XLEN-1:0]    rs2,
    input  logic [11:0]        imm,
    input  logic [XLEN-1:0]    PC,
    input  logic [NUM_OPS-1:0] instructions,
    input  logic               ALUenabled,
    alu_if.master              dmem,
    output logic [XLEN-1:0]    ALUoutput
);

    op_vec_t         sel_s;
    logic [XLEN-1:0] simm_s;
    logic [XLEN-1:0] uimm_s;
    logic [XLEN-1:0] eff_addr_s;
    logic [4:0]      shamt_i_s;
    logic [4:0]      shamt_r_s;
    logic            is_load_s;
    logic            is_store_s;
    load_kind_e      load_kind_s;
    logic [XLEN-1:0] load_data_s;
    logic [XLEN-1:0] result_s;
    logic [XLEN-1:0] alu_out_d;
    logic [XLEN-1:0] alu_out_q;

    // Operand preparation and memory-access classification.
    always_comb begin
        sel_s      = lowest_set(instructions);
        simm_s     = {{20{imm[11]}}, imm};
        uimm_s     = {imm, 20'd0};
        eff_addr_s = rs1 + simm_s;
        shamt_i_s  = imm[4:0];
        shamt_r_s  = rs2[4:0];
        is_load_s  = |sel_s[OP_LHU:OP_LB];
        is_store_s = |sel_s[OP_SW:OP_SB];
        if (sel_s[OP_LB]) begin
            load_kind_s = LD_B;
        end else if (sel_s[OP_LH]) begin
            load_kind_s = LD_H;
        end else if (sel_s[OP_LW]) begin
            load_kind_s = LD_W;
        end else if (sel_s[OP_LBU]) begin
            load_kind_s = LD_BU;
        end else if (sel_s[OP_LHU]) begin
            load_kind_s = LD_HU;
        end else begin
            load_kind_s = LD_NONE;
        end
    end

    alu_load_align u_load_align (
        .kind      (load_kind_s),
        .lane      (eff_addr_s[1:0]),
        .rd_data   (dmem.dmem_rd_data),
        .load_data (load_data_s)
    );

    // Data-memory port: strobes are suppressed while disabled or in reset.
    always_comb begin
        dmem.addr  = eff_addr_s[DADDR_W-1:0];
        dmem.rd_en = rst_n & ALUenabled & is_load_s;
        dmem.wr_en = rst_n & ALUenabled & is_store_s;
        if (sel_s[OP_SB]) begin
            dmem.dmem_wr_data = {24'd0, rs2[7:0]};
        end else if (sel_s[OP_SH]) begin
            dmem.dmem_wr_data = {16'd0, rs2[15:0]};
        end else if (sel_s[OP_SW]) begin
            dmem.dmem_wr_data = rs2;
        end else begin
            dmem.dmem_wr_data = {XLEN{1'b0}};
        end
    end

    // Result mux; stores, FENCE, system ops and empty vectors fall through to zero.
    always_comb begin
        result_s = {XLEN{1'b0}};
        case (1'b1)
            sel_s[OP_LUI]:   result_s = uimm_s;
            sel_s[OP_AUIPC]: result_s = PC + uimm_s;
            sel_s[OP_JAL],
            sel_s[OP_JALR]:  result_s = PC + 32'd4;
            sel_s[OP_BEQ]:   result_s = {31'd0, rs1 == rs2};
            sel_s[OP_BNE]:   result_s = {31'd0, rs1 != rs2};
            sel_s[OP_BLT]:   result_s = {31'd0, $signed(rs1) < $signed(rs2)};
            sel_s[OP_BGE]:   result_s = {31'd0, $signed(rs1) >= $signed(rs2)};
            sel_s[OP_BLTU]:  result_s = {31'd0, rs1 < rs2};
            sel_s[OP_BGEU]:  result_s = {31'd0, rs1 >= rs2};
            sel_s[OP_LB],
            sel_s[OP_LH],
            sel_s[OP_LW],
            sel_s[OP_LBU],
            sel_s[OP_LHU]:   result_s = load_data_s;
            sel_s[OP_ADDI]:  result_s = rs1 + simm_s;
            sel_s[OP_SLTI]:  result_s = {31'd0, $signed(rs1) < $signed(simm_s)};
            sel_s[OP_SLTIU]: result_s = {31'd0, rs1 < simm_s};
            sel_s[OP_XORI]:  result_s = rs1 ^ simm_s;
            sel_s[OP_ORI]:   result_s = rs1 | simm_s;
            sel_s[OP_ANDI]:  result_s = rs1 & simm_s;
            sel_s[OP_SLLI]:  result_s = rs1 << shamt_i_s;
            sel_s[OP_SRLI]:  result_s = rs1 >> shamt_i_s;
            sel_s[OP_SRAI]:  result_s = $unsigned($signed(rs1) >>> shamt_i_s);
            sel_s[OP_ADD]:   result_s = rs1 + rs2;
            sel_s[OP_SUB]:   result_s = rs1 - rs2;
            sel_s[OP_SLL]:   result_s = rs1 << shamt_r_s;
            sel_s[OP_SLT]:   result_s = {31'd0, $signed(rs1) < $signed(rs2)};
            sel_s[OP_SLTU]:  result_s = {31'd0, rs1 < rs2};
            sel_s[OP_XOR]:   result_s = rs1 ^ rs2;
            sel_s[OP_SRL]:   result_s = rs1 >> shamt_r_s;
            sel_s[OP_SRA]:   result_s = $unsigned($signed(rs1) >>> shamt_r_s);
            sel_s[OP_OR]:    result_s = rs1 | rs2;
            sel_s[OP_AND]:   result_s = rs1 & rs2;
            default:         result_s = {XLEN{1'b0}};
        endcase
    end

    // Capture only when enabled; otherwise the previous result is held.
    always_comb begin
        if (ALUenabled) begin
            alu_out_d = result_s;
        end else begin
            alu_out_d = alu_out_q;
        end
    end

    // Result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out_q <= {XLEN{1'b0}};
        end else begin
            alu_out_q <= alu_out_d;
        end
    end

    assign ALUoutput = alu_out_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed checks from the test plan followed by
// randomized instructions compared against a behavioural reference model.
module tb_alu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] rs1, rs2, PC;
    logic [11:0] imm;
    logic [38:0] instructions;
    logic        ALUenabled;
    logic [31:0] ALUoutput;

    int n_checks = 0;
    int n_errors = 0;

    alu_if dmem_bus ();

    alu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rs1          (rs1),
        .rs2          (rs2),
        .imm          (imm),
        .PC           (PC),
        .instructions (instructions),
        .ALUenabled   (ALUenabled),
        .dmem         (dmem_bus),
        .ALUoutput    (ALUoutput)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [38:0] onehot(input int k);
        logic [38:0] v;
        v    = 39'd0;
        v[k] = 1'b1;
        return v;
    endfunction

    function automatic int first_op(input logic [38:0] vec);
        int op;
        op = -1;
        for (int i = 38; i >= 0; i--) begin
            if (vec[i]) op = i;
        end
        return op;
    endfunction

    function automatic logic [31:0] eff_addr(input logic [31:0] a, input logic [11:0] im);
        int si;
        si = int'($signed(im));
        return a + 32'(si);
    endfunction

    // Reference model of the captured result, written from the instruction semantics.
    function automatic logic [31:0] model(input logic [38:0] vec, input logic [31:0] a,
                                          input logic [31:0] b, input logic [11:0] im,
                                          input logic [31:0] pc, input logic [31:0] rd);
        int          op, sa, sb, si, lane;
        logic [31:0] usi, ea, u;
        logic [7:0]  b8;
        logic [15:0] h16;
        op   = first_op(vec);
        sa   = int'(a);
        sb   = int'(b);
        si   = int'($signed(im));
        usi  = 32'(si);
        ea   = eff_addr(a, im);
        lane = int'(ea % 32'd4);
        u    = 32'(im) * 32'd1048576;
        b8   = 8'(rd >> (8 * lane));
        h16  = 16'(rd >> (16 * (lane / 2)));
        case (op)
            OP_LUI:   return u;
            OP_AUIPC: return pc + u;
            OP_JAL, OP_JALR: return pc + 32'd4;
            OP_BEQ:   return (a == b) ? 32'd1 : 32'd0;
            OP_BNE:   return (a != b) ? 32'd1 : 32'd0;
            OP_BLT:   return (sa < sb) ? 32'd1 : 32'd0;
            OP_BGE:   return (sa >= sb) ? 32'd1 : 32'd0;
            OP_BLTU:  return (a < b) ? 32'd1 : 32'd0;
            OP_BGEU:  return (a >= b) ? 32'd1 : 32'd0;
            OP_LB:    return 32'(int'($signed(b8)));
            OP_LH:    return 32'(int'($signed(h16)));
            OP_LW:    return rd;
            OP_LBU:   return 32'(b8);
            OP_LHU:   return 32'(h16);
            OP_ADDI:  return a + usi;
            OP_SLTI:  return (sa < si) ? 32'd1 : 32'd0;
            OP_SLTIU: return (a < usi) ? 32'd1 : 32'd0;
            OP_XORI:  return a ^ usi;
            OP_ORI:   return a | usi;
            OP_ANDI:  return a & usi;
            OP_SLLI:  return a << im[4:0];
            OP_SRLI:  return a >> im[4:0];
            OP_SRAI:  return 32'(sa >>> im[4:0]);
            OP_ADD:   return a + b;
            OP_SUB:   return a - b;
            OP_SLL:   return a << b[4:0];
            OP_SLT:   return (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU:  return (a < b) ? 32'd1 : 32'd0;
            OP_XOR:   return a ^ b;
            OP_SRL:   return a >> b[4:0];
            OP_SRA:   return 32'(sa >>> b[4:0]);
            OP_OR:    return a | b;
            OP_AND:   return a & b;
            default:  return 32'd0;
        endcase
    endfunction

    initial begin
        logic [31:0] exp_out;
        logic [31:0] exp_wd;
        int          op;

        // Reset with a load selected: output and strobes must be quiet.
        rst_n                 = 1'b0;
        rs1                   = 32'd5;
        rs2                   = 32'd4;
        imm                   = 12'd12;
        PC                    = 32'd2;
        ALUenabled            = 1'b1;
        instructions          = onehot(OP_LW);
        dmem_bus.dmem_rd_data = 32'h0000F000;
        #1;
        chk("reset_out", ALUoutput, 32'd0);
        chk("reset_rd_en", {31'd0, dmem_bus.rd_en}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        instructions = onehot(OP_ADDI); tick(); chk("addi", ALUoutput, 32'd17);
        instructions = onehot(OP_SUB);  tick(); chk("sub", ALUoutput, 32'd1);
        instructions = onehot(OP_XOR);  tick(); chk("xor", ALUoutput, 32'd1);
        instructions = onehot(OP_OR);   tick(); chk("or", ALUoutput, 32'd5);
        instructions = onehot(OP_SRL);  tick(); chk("srl", ALUoutput, 32'd0);
        instructions = onehot(OP_SLT);  tick(); chk("slt", ALUoutput, 32'd0);
        instructions = onehot(OP_LUI);  tick(); chk("lui", ALUoutput, 32'h00C00000);
        instructions = onehot(OP_AUIPC); tick(); chk("auipc", ALUoutput, 32'h00C00002);
        instructions = onehot(OP_JAL);  tick(); chk("jal", ALUoutput, 32'd6);
        instructions = onehot(OP_BEQ);  tick(); chk("beq", ALUoutput, 32'd0);
        instructions = onehot(OP_BNE);  tick(); chk("bne", ALUoutput, 32'd1);
        instructions = onehot(OP_BGE);  tick(); chk("bge", ALUoutput, 32'd1);
        instructions = onehot(OP_BLTU); tick(); chk("bltu", ALUoutput, 32'd0);
        rs1 = 32'hFFFFFFFF;
        rs2 = 32'd1;
        instructions = onehot(OP_BLT);  tick(); chk("blt_neg", ALUoutput, 32'd1);
        instructions = onehot(OP_BGEU); tick(); chk("bgeu_big", ALUoutput, 32'd1);

        // Memory accesses at addr 17 (lane 1).
        rs1 = 32'd5;
        rs2 = 32'd4;
        instructions = onehot(OP_SW);
        #1;
        chk("sw_addr", {17'd0, dmem_bus.addr}, 32'd17);
        chk("sw_wr_en", {31'd0, dmem_bus.wr_en}, 32'd1);
        chk("sw_wr_data", dmem_bus.dmem_wr_data, 32'd4);
        tick();
        chk("sw_out", ALUoutput, 32'd0);
        instructions = onehot(OP_LB);
        #1;
        chk("lb_rd_en", {31'd0, dmem_bus.rd_en}, 32'd1);
        chk("lb_wr_data", dmem_bus.dmem_wr_data, 32'd0);
        tick();
        chk("lb_out", ALUoutput, 32'hFFFFFFF0);
        instructions = onehot(OP_LBU); tick(); chk("lbu_out", ALUoutput, 32'h000000F0);

        // Disabled: result holds, strobes stay low even for a load.
        ALUenabled   = 1'b0;
        instructions = onehot(OP_ADD);
        tick();
        chk("dis_add_hold", ALUoutput, 32'h000000F0);
        instructions = onehot(OP_LW);
        #1;
        chk("dis_rd_en", {31'd0, dmem_bus.rd_en}, 32'd0);
        tick();
        chk("dis_lw_hold", ALUoutput, 32'h000000F0);
        ALUenabled   = 1'b1;
        instructions = onehot(OP_ADD);
        tick();
        chk("add", ALUoutput, 32'd9);

        // Mid-cycle reset pulse clears the result without a clock edge.
        instructions = onehot(OP_LW);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out", ALUoutput, 32'd0);
        chk("midrst_rd_en", {31'd0, dmem_bus.rd_en}, 32'd0);
        rst_n        = 1'b1;
        instructions = onehot(OP_ADDI);
        tick();
        chk("post_rst_addi", ALUoutput, 32'd17);

        instructions = 39'd0;        tick(); chk("zero_vec", ALUoutput, 32'd0);
        instructions = 39'h3;        tick(); chk("multi_lui", ALUoutput, 32'h00C00000);

        // Randomized instructions against the reference model.
        exp_out = ALUoutput === 32'h00C00000 ? 32'h00C00000 : 32'h00C00000;
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                instructions = {7'($urandom), $urandom};
            end else begin
                instructions = onehot(int'($urandom_range(0, 38)));
            end
            rs1                   = $urandom;
            rs2                   = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
            imm                   = 12'($urandom);
            PC                    = $urandom;
            dmem_bus.dmem_rd_data = $urandom;
            ALUenabled            = ($urandom_range(0, 7) != 0);
            op                    = first_op(instructions);
            case (op)
                OP_SB:   exp_wd = {24'd0, rs2[7:0]};
                OP_SH:   exp_wd = {16'd0, rs2[15:0]};
                OP_SW:   exp_wd = rs2;
                default: exp_wd = 32'd0;
            endcase
            #1;
            chk("rnd_addr", {17'd0, dmem_bus.addr}, {17'd0, 15'(eff_addr(rs1, imm))});
            chk("rnd_rd_en", {31'd0, dmem_bus.rd_en},
                (ALUenabled && op >= OP_LB && op <= OP_LHU) ? 32'd1 : 32'd0);
            chk("rnd_wr_en", {31'd0, dmem_bus.wr_en},
                (ALUenabled && op >= OP_SB && op <= OP_SW) ? 32'd1 : 32'd0);
            chk("rnd_wr_data", dmem_bus.dmem_wr_data, exp_wd);
            if (ALUenabled) begin
                exp_out = model(instructions, rs1, rs2, imm, PC, dmem_bus.dmem_rd_data);
            end
            tick();
            chk("rnd_out", ALUoutput, exp_out);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
